// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state
// encoding, grant-side encoding and default bus widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one slow-memory port between the I-cache and the D-cache.
// One side is granted at a time, its request is registered onto the shared
// port, and the memory response is routed back to the granted side only.
// Contention alternates using the side granted last.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              proc_reset,

    input  logic              mem_read_I,
    input  logic              mem_write_I,
    input  logic [ADDR_W-1:0] mem_addr_I,
    input  logic [DATA_W-1:0] mem_wdata_I,
    output logic [DATA_W-1:0] mem_rdata_I,
    output logic              mem_ready_I,

    input  logic              mem_read_D,
    input  logic              mem_write_D,
    input  logic [ADDR_W-1:0] mem_addr_D,
    input  logic [DATA_W-1:0] mem_wdata_D,
    output logic [DATA_W-1:0] mem_rdata_D,
    output logic              mem_ready_D,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        state_q, state_d;
    logic              lastGrant_q, lastGrant_d;
    logic              grant_q, grant_d;
    logic              memRead_q, memRead_d;
    logic              memWrite_q, memWrite_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [DATA_W-1:0] rdataI_q, rdataI_d;
    logic [DATA_W-1:0] rdataD_q, rdataD_d;
    logic              readyI_q, readyI_d;
    logic              readyD_q, readyD_d;

    logic              activeI;
    logic              activeD;
    logic              pickSide;
    logic              selRead;
    logic              selWrite;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;

    // Choose a winner among active requesters and mux its request fields.
    always_comb begin
        activeI = mem_read_I | mem_write_I;
        activeD = mem_read_D | mem_write_D;
        if (activeI && activeD) begin
            pickSide = ~lastGrant_q;
        end else if (activeD) begin
            pickSide = GNT_D;
        end else begin
            pickSide = GNT_I;
        end
        selRead  = (pickSide == GNT_D) ? mem_read_D  : mem_read_I;
        selWrite = (pickSide == GNT_D) ? mem_write_D : mem_write_I;
        selAddr  = (pickSide == GNT_D) ? mem_addr_D  : mem_addr_I;
        selWdata = (pickSide == GNT_D) ? mem_wdata_D : mem_wdata_I;
    end

    // Next-state and registered-output logic of the grant/busy/done sequence.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        grant_d     = grant_q;
        memRead_d   = memRead_q;
        memWrite_d  = memWrite_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        rdataI_d    = rdataI_q;
        rdataD_d    = rdataD_q;
        readyI_d    = 1'b0;
        readyD_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (activeI || activeD) begin
                    grant_d     = pickSide;
                    lastGrant_d = pickSide;
                    memWrite_d  = selWrite;
                    memRead_d   = selRead & ~selWrite;
                    memAddr_d   = selAddr;
                    memWdata_d  = selWdata;
                    state_d     = BUSY;
                end else begin
                    memRead_d  = 1'b0;
                    memWrite_d = 1'b0;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    if (memRead_q) begin
                        if (grant_q == GNT_D) begin
                            rdataD_d = mem_rdata;
                        end else begin
                            rdataI_d = mem_rdata;
                        end
                    end
                    memRead_d  = 1'b0;
                    memWrite_d = 1'b0;
                    readyI_d   = (grant_q == GNT_I);
                    readyD_d   = (grant_q == GNT_D);
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                memRead_d  = 1'b0;
                memWrite_d = 1'b0;
            end
        endcase
    end

    // FSM state register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant bookkeeping, shared-port capture and per-side response registers.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            lastGrant_q <= GNT_I;
            grant_q     <= GNT_I;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            rdataI_q    <= '0;
            rdataD_q    <= '0;
            readyI_q    <= 1'b0;
            readyD_q    <= 1'b0;
        end else begin
            lastGrant_q <= lastGrant_d;
            grant_q     <= grant_d;
            memRead_q   <= memRead_d;
            memWrite_q  <= memWrite_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            rdataI_q    <= rdataI_d;
            rdataD_q    <= rdataD_d;
            readyI_q    <= readyI_d;
            readyD_q    <= readyD_d;
        end
    end

    assign mem_read    = memRead_q;
    assign mem_write   = memWrite_q;
    assign mem_addr    = memAddr_q;
    assign mem_wdata   = memWdata_q;
    assign mem_rdata_I = rdataI_q;
    assign mem_rdata_D = rdataD_q;
    assign mem_ready_I = readyI_q;
    assign mem_ready_D = readyD_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one slow-memory port between the instruction cache and the data cache. It sits between the two `cache` instances and the external memory, replacing their separate memory channels with a single one. It grants one cache at a time, registers the winning request onto the shared port, and returns the memory response to the granted cache only. Each cache sees exactly the same handshake it would get from a private memory.

## Interface
- `ADDR_W`, default 28: line address width (address bits [31:4]).
- `DATA_W`, default 128: line data width.

Ports, clock and reset first:
- `clk` in 1: single clock; all state updates on its rising edge.
- `proc_reset` in 1: reset, asynchronous and active-high.
- `mem_read_I` in 1: I-cache read request, held until serviced.
- `mem_write_I` in 1: I-cache write request, held until serviced.
- `mem_addr_I` in `ADDR_W`: I-cache line address.
- `mem_wdata_I` in `DATA_W`: I-cache write line.
- `mem_rdata_I` out `DATA_W`: read line returned to the I-cache.
- `mem_ready_I` out 1: one-cycle completion pulse to the I-cache.
- `mem_read_D` in 1: D-cache read request; D-side counterpart of `mem_read_I`.
- `mem_write_D` in 1: D-cache write request; counterpart of `mem_write_I`.
- `mem_addr_D` in `ADDR_W`: D-cache line address.
- `mem_wdata_D` in `DATA_W`: D-cache write line.
- `mem_rdata_D` out `DATA_W`: read line returned to the D-cache.
- `mem_ready_D` out 1: one-cycle completion pulse to the D-cache.
- `mem_read` out 1: shared-memory read strobe, registered.
- `mem_write` out 1: shared-memory write strobe, registered.
- `mem_addr` out `ADDR_W`: shared-memory address, registered.
- `mem_wdata` out `DATA_W`: shared-memory write data, registered.
- `mem_rdata` in `DATA_W`: shared-memory read data.
- `mem_ready` in 1: shared-memory completion pulse.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE:
  - A requester is "active" when its `mem_read_X | mem_write_X` is high.
  - If exactly one requester is active, grant it.
  - If both are active, grant the side opposite to `last_grant`.
  - On a grant, capture address, wdata and direction into output registers, update `last_grant`, and move to BUSY.
  - With no request, stay in IDLE with the strobes low.
- Direction: if a requester raises read and write together, write wins; it is issued as a write only.
- BUSY:
  - Hold `mem_read`/`mem_write`/`mem_addr`/`mem_wdata` constant.
  - Changes on either cache's inputs are ignored.
  - On `mem_ready`, latch `mem_rdata` into the granted side's rdata register, clear both strobes, and move to DONE.
- DONE:
  - Assert `mem_ready_X` for the granted side only, for exactly one cycle.
  - Unconditionally return to IDLE.
  - The granted cache's request, still visible this cycle, is not re-arbitrated.
- The non-granted side's request is never dropped; it is serviced at the next IDLE.
- `mem_rdata_X` holds its last latched value until that side's next completed read. Writes do not update it.
- Reset values: all outputs 0, FSM = IDLE, `last_grant` = I, so D wins the first contention.
- Asserting `proc_reset` mid-transaction forces IDLE with strobes low immediately. The in-flight transaction is abandoned, and no `mem_ready_X` is issued for it.

## Timing
- Grant latency: a request sampled at edge n drives the shared strobes from cycle n+1.
- Response latency: `mem_ready` high in cycle k gives `mem_ready_X` high in cycle k+1 with valid `mem_rdata_X`. The FSM is back in IDLE at cycle k+2.
- Minimum occupancy is 3 cycles per transaction plus the memory latency.
- Back-to-back: a waiting requester is granted at the IDLE following DONE, with one idle cycle between transactions.
- A `mem_ready` seen in IDLE or DONE is ignored.
- Outputs are registered; there are no combinational paths from cache inputs to memory outputs.

## Structure
- Shared package holds:
  - state encoding `arb_state_t` {IDLE, BUSY, DONE};
  - grant encoding `GNT_I = 1'b0`, `GNT_D = 1'b1`;
  - `ADDR_W`/`DATA_W` defaults.
- Single module; no sub-module is needed. The request mux and capture registers are inline.

## Test plan
- **Single I read:** I-read at addr 0x0000040, memory `mem_ready` after 4 cycles with rdata 0x0123…CDEF -> `mem_read` high for cycles 1–4, `mem_ready_I` one cycle at cycle 5 with matching rdata, `mem_ready_D` stays 0.
- **Simultaneous requests after reset:** I read 0x10 and D write 0x20, wdata 0xAA…AA -> D served first (`mem_write`, addr 0x20), then I (`mem_read`, addr 0x10). A second contention serves I first.
- **D write-back then allocate:** D write 0x30 then read 0x31 -> two serialized transactions. `mem_rdata_D` unchanged after the write and updated after the read.
- **Input change while BUSY:** D changes its address mid-transaction -> `mem_addr` stays at the captured value.
- **Reset in BUSY:** assert `proc_reset` during BUSY -> strobes 0 in the same cycle, no ready pulse, a fresh request is served normally after release.
- **Spurious ready:** `mem_ready` pulsed in IDLE -> no `mem_ready_I`/`mem_ready_D`, state stays IDLE.
